// File: rtl/risc_pkg.sv
// Shared opcode constants and sequencer state encoding for the simple RISC core.
// The ALU and datapath import the same opcode values.
package risc_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    StInstAddr  = 4'd0,
    StInstFetch = 4'd1,
    StInstLoad  = 4'd2,
    StIdle      = 4'd3,
    StOpAddr    = 4'd4,
    StOpFetch   = 4'd5,
    StAluOp     = 4'd6,
    StStore     = 4'd7,
    StHalt      = 4'd8
  } state_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: instruction fetch, operand fetch, ALU op and store,
// eight cycles per instruction with stalls on mem_ready.
module instr_sequencer #(
  parameter int unsigned OPC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             ac_zero,
  input  logic             mem_ready,
  input  logic             go,
  output logic             sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             data_e,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             halt
);
  import risc_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] opc;
  logic       aluop;

  assign opc   = 3'(ir_opcode);
  assign aluop = is_aluop(opc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInstAddr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    data_e  = 1'b0;
    ld_pc   = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;

    unique case (state_q)
      StInstAddr: begin
        sel     = 1'b1;
        state_d = StInstFetch;
      end
      StInstFetch: begin
        sel    = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) state_d = StInstLoad;
      end
      StInstLoad: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        ld_ir   = 1'b1;
        state_d = StIdle;
      end
      StIdle: begin
        sel     = 1'b1;
        mem_rd  = 1'b1;
        state_d = StOpAddr;
      end
      StOpAddr: begin
        inc_pc  = 1'b1;
        state_d = (opc == OP_HLT) ? StHalt : StOpFetch;
      end
      StOpFetch: begin
        mem_rd = aluop;
        // Only operand-reading opcodes wait on memory.
        if (!aluop || mem_ready) state_d = StAluOp;
      end
      StAluOp: begin
        mem_rd  = aluop;
        inc_pc  = (opc == OP_SKZ) && ac_zero;
        ld_pc   = (opc == OP_JMP);
        data_e  = (opc == OP_STO);
        state_d = StStore;
      end
      StStore: begin
        mem_rd  = aluop;
        ld_ac   = aluop;
        mem_wr  = (opc == OP_STO);
        data_e  = (opc == OP_STO);
        ld_pc   = (opc == OP_JMP);
        state_d = StInstAddr;
      end
      StHalt: begin
        halt = 1'b1;
        sel  = 1'b1;
        if (go) state_d = StInstAddr;
      end
      default: begin
        state_d = StInstAddr;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed table, hand-built corner sequences and
// randomized instruction streams checked against a per-instruction trace model.
module tb_instr_sequencer;

  localparam logic [8:0] SEL  = 9'h100;
  localparam logic [8:0] RD   = 9'h080;
  localparam logic [8:0] WR   = 9'h040;
  localparam logic [8:0] LDIR = 9'h020;
  localparam logic [8:0] LDAC = 9'h010;
  localparam logic [8:0] DE   = 9'h008;
  localparam logic [8:0] LDPC = 9'h004;
  localparam logic [8:0] INC  = 9'h002;
  localparam logic [8:0] HB   = 9'h001;

  logic       clk = 1'b0;
  logic       rst, ac_zero, mem_ready, go;
  logic [2:0] ir_opcode;
  logic       sel, mem_rd, mem_wr, ld_ir, ld_ac, data_e, ld_pc, inc_pc, halt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.OPC_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .ir_opcode(ir_opcode),
    .ac_zero  (ac_zero),
    .mem_ready(mem_ready),
    .go       (go),
    .sel      (sel),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .ld_ir    (ld_ir),
    .ld_ac    (ld_ac),
    .data_e   (data_e),
    .ld_pc    (ld_pc),
    .inc_pc   (inc_pc),
    .halt     (halt)
  );

  // One cycle of stimulus plus the outputs the specification demands for it.
  typedef struct packed {
    logic       rst;
    logic       go;
    logic       mr;
    logic       az;
    logic [2:0] opc;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic       az;
    int         sf1, sf2;
    int         inc, ldpc, wr, ldac, rd;
  } tcase_t;

  vec_t   q[$];
  tcase_t tbl[10];

  function automatic logic [8:0] outs();
    return {sel, mem_rd, mem_wr, ld_ir, ld_ac, data_e, ld_pc, inc_pc, halt};
  endfunction

  function automatic logic rb(input logic rnd, input logic dflt);
    return rnd ? 1'($urandom & 1) : dflt;
  endfunction

  task automatic check_vec(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b (sel rd wr ldir ldac de ldpc inc halt)",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic mr, input logic az, input logic go_v, input logic [2:0] opc,
                     input logic [8:0] exp);
    vec_t v;
    v.rst = 1'b0;
    v.go  = go_v;
    v.mr  = mr;
    v.az  = az;
    v.opc = opc;
    v.exp = exp;
    q.push_back(v);
  endtask

  // Expected cycle trace of one instruction, written from the per-state output table.
  task automatic build(input logic [2:0] op, input logic rnd, input logic azf, input int sf1,
                       input int sf2, input int halt_len);
    logic       alu;
    logic       az;
    logic [2:0] early;
    logic [8:0] e;
    alu   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    early = rnd ? 3'($urandom) : op;
    add(rb(rnd, 1'b1), rb(rnd, azf), rb(rnd, 1'b0), early, SEL);
    for (int i = 0; i < sf1; i++) add(1'b0, rb(rnd, azf), rb(rnd, 1'b0), early, SEL | RD);
    add(1'b1, rb(rnd, azf), rb(rnd, 1'b0), early, SEL | RD);
    add(rb(rnd, 1'b1), rb(rnd, azf), rb(rnd, 1'b0), early, SEL | RD | LDIR);
    add(rb(rnd, 1'b1), rb(rnd, azf), rb(rnd, 1'b0), op, SEL | RD);
    add(rb(rnd, 1'b1), rb(rnd, azf), rb(rnd, 1'b0), op, INC);
    if (op == 3'd0) begin
      for (int i = 0; i < halt_len; i++) add(rb(rnd, 1'b1), rb(rnd, azf), 1'b0, op, SEL | HB);
      add(rb(rnd, 1'b1), rb(rnd, azf), 1'b1, op, SEL | HB);
      return;
    end
    if (alu) begin
      for (int i = 0; i < sf2; i++) add(1'b0, rb(rnd, azf), rb(rnd, 1'b0), op, RD);
      add(1'b1, rb(rnd, azf), rb(rnd, 1'b0), op, RD);
    end else begin
      add((sf2 > 0) ? 1'b0 : 1'b1, rb(rnd, azf), rb(rnd, 1'b0), op, 9'h000);
    end
    az = rb(rnd, azf);
    e  = (alu ? RD : 9'h000) | ((op == 3'd1 && az) ? INC : 9'h000) |
         ((op == 3'd7) ? LDPC : 9'h000) | ((op == 3'd6) ? DE : 9'h000);
    add(rb(rnd, 1'b1), az, rb(rnd, 1'b0), op, e);
    e  = (alu ? (RD | LDAC) : 9'h000) | ((op == 3'd6) ? (WR | DE) : 9'h000) |
         ((op == 3'd7) ? LDPC : 9'h000);
    add(rb(rnd, 1'b1), rb(rnd, azf), rb(rnd, 1'b0), op, e);
  endtask

  // Keep the first k cycles and assert rst on the last of them.
  task automatic cut_with_reset(input int k, input logic go_v);
    while (q.size() > k) void'(q.pop_back());
    q[k-1].rst = 1'b1;
    q[k-1].go  = go_v;
  endtask

  // Entered just after a negedge; returns just after a negedge.
  task automatic run_q(input string name, output int inc_n, output int ldpc_n, output int wr_n,
                       output int ldac_n, output int rd_n);
    vec_t       v;
    logic [8:0] a;
    inc_n = 0; ldpc_n = 0; wr_n = 0; ldac_n = 0; rd_n = 0;
    while (q.size() > 0) begin
      v         = q.pop_front();
      rst       = v.rst;
      go        = v.go;
      mem_ready = v.mr;
      ac_zero   = v.az;
      ir_opcode = v.opc;
      #1;
      a = outs();
      check_vec(name, a, v.exp);
      inc_n  += int'(inc_pc);
      ldpc_n += int'(ld_pc);
      wr_n   += int'(mem_wr);
      ldac_n += int'(ld_ac);
      rd_n   += int'(mem_rd);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    int         ci, cp, cw, ca, cr;
    logic [2:0] op;

    tbl[0] = '{3'd2, 1'b0, 0, 0, 1, 0, 0, 1, 6};  // ADD
    tbl[1] = '{3'd1, 1'b1, 0, 0, 2, 0, 0, 0, 3};  // SKZ taken
    tbl[2] = '{3'd1, 1'b0, 0, 0, 1, 0, 0, 0, 3};  // SKZ not taken
    tbl[3] = '{3'd7, 1'b1, 0, 0, 1, 2, 0, 0, 3};  // JMP
    tbl[4] = '{3'd6, 1'b0, 0, 0, 1, 0, 1, 0, 3};  // STO
    tbl[5] = '{3'd5, 1'b0, 0, 2, 1, 0, 0, 1, 8};  // LDA, 2 operand stalls
    tbl[6] = '{3'd2, 1'b1, 3, 0, 1, 0, 0, 1, 9};  // ADD, 3 fetch stalls
    tbl[7] = '{3'd1, 1'b1, 0, 2, 2, 0, 0, 0, 3};  // SKZ ignores mem_ready in OP_FETCH
    tbl[8] = '{3'd4, 1'b1, 1, 0, 1, 0, 0, 1, 7};  // XOR
    tbl[9] = '{3'd3, 1'b0, 1, 1, 1, 0, 0, 1, 8};  // AND

    rst = 1'b1; go = 1'b1; mem_ready = 1'b0; ac_zero = 1'b0; ir_opcode = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check_vec("reset_state", outs(), SEL);
    go  = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) begin
      build(tbl[i].op, 1'b0, tbl[i].az, tbl[i].sf1, tbl[i].sf2, 0);
      run_q($sformatf("tbl%0d_trace", i), ci, cp, cw, ca, cr);
      check_int($sformatf("tbl%0d_inc_pc", i), ci, tbl[i].inc);
      check_int($sformatf("tbl%0d_ld_pc", i), cp, tbl[i].ldpc);
      check_int($sformatf("tbl%0d_mem_wr", i), cw, tbl[i].wr);
      check_int($sformatf("tbl%0d_ld_ac", i), ca, tbl[i].ldac);
      check_int($sformatf("tbl%0d_mem_rd", i), cr, tbl[i].rd);
    end

    // HLT: halt held 20 cycles, then go restarts.
    build(3'd0, 1'b0, 1'b0, 0, 0, 20);
    run_q("hlt_hold", ci, cp, cw, ca, cr);
    check_int("hlt_inc_pc", ci, 1);
    build(3'd2, 1'b0, 1'b0, 0, 0, 0);
    run_q("after_go", ci, cp, cw, ca, cr);

    // Reset during ALU_OP of STO: no store cycle follows.
    build(3'd6, 1'b0, 1'b0, 0, 0, 0);
    cut_with_reset(7, 1'b0);
    run_q("rst_aluop", ci, cp, cw, ca, cr);
    check_int("rst_aluop_mem_wr", cw, 0);
    build(3'd5, 1'b0, 1'b0, 0, 0, 0);
    run_q("after_rst_aluop", ci, cp, cw, ca, cr);
    check_int("after_rst_ld_ac", ca, 1);

    // Reset during an INST_FETCH stall, then rst with go while halted.
    build(3'd2, 1'b0, 1'b0, 3, 0, 0);
    cut_with_reset(3, 1'b1);
    run_q("rst_stall", ci, cp, cw, ca, cr);
    check_int("rst_stall_inc_pc", ci, 0);
    build(3'd0, 1'b0, 1'b0, 0, 0, 2);
    q[q.size()-1].rst = 1'b1;
    run_q("rst_go_halt", ci, cp, cw, ca, cr);
    build(3'd7, 1'b0, 1'b0, 0, 0, 0);
    run_q("after_rst_halt", ci, cp, cw, ca, cr);

    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(9, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
      build(op, 1'b1, 1'b0, ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 1),
            $urandom_range(3, 0), $urandom_range(4, 0));
      run_q($sformatf("rand%0d_op%0d", n, op), ci, cp, cw, ca, cr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
